// File: rtl/brc_pkg.sv
// Shared definitions for the branch resolve controller: FSM encoding,
// the largest legal compare mode and the requester id constants.
package brc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } brc_state_e;

  // Modes above this value are illegal when mode checking is compiled in
  localparam int unsigned MODE_MAX = 6;

  localparam logic REQ_ID_BRANCH = 1'b0;  // ID-stage branch
  localparam logic REQ_ID_TRAP   = 1'b1;  // EX-stage conditional trap

endpackage

// File: rtl/brc_starve_arb.sv
// Two-requester fixed-priority arbiter with starvation relief.
// Requester 0 normally wins; once requester 1 has lost STARVE_LIM
// arbitration cycles in a row it is granted ahead of requester 0.
module brc_starve_arb #(
  parameter int STARVE_LIM = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_idle,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);
  import brc_pkg::*;

  localparam int CW = $clog2(STARVE_LIM + 2);

  logic [CW-1:0] r_cnt;
  logic          w_starved;

  assign w_starved = (r_cnt == CW'(STARVE_LIM));

  // Grant: req0 first unless req1 has been starved long enough
  always_comb begin
    o_grant = 2'b00;
    if (i_valid[REQ_ID_TRAP] && (w_starved || !i_valid[REQ_ID_BRANCH]))
      o_grant = 2'b10;
    else if (i_valid[REQ_ID_BRANCH])
      o_grant = 2'b01;
  end

  // Starvation counter: counts lost IDLE cycles for req1, saturating
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_idle) begin
      if (o_grant[REQ_ID_TRAP])
        r_cnt <= '0;
      else if (i_valid[REQ_ID_TRAP] && !w_starved)
        r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: arbitrates the ID branch and EX trap
// requesters onto one external comparator, one compare in flight.
// Optional feature: define BRC_MODE_CHECK_EN to flag modes > MODE_MAX
// (RspErr=1, RspResult=0, comparator mode forced to 0).
module branch_resolve_ctrl #(
  parameter int DW         = 32,
  parameter int MODE_W     = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                BRC_i_Clk,
  input  logic                BRC_i_Reset,
  input  logic [1:0]          BRC_i_ReqValid,
  input  logic [2*DW-1:0]     BRC_i_ReqRs,
  input  logic [2*DW-1:0]     BRC_i_ReqRt,
  input  logic [2*MODE_W-1:0] BRC_i_ReqMode,
  output logic [1:0]          BRC_o_ReqReady,
  output logic [DW-1:0]       BRC_o_CmpRs,
  output logic [DW-1:0]       BRC_o_CmpRt,
  output logic [MODE_W-1:0]   BRC_o_CmpMode,
  input  logic                BRC_i_CmpResult,
  output logic                BRC_o_RspValid,
  output logic                BRC_o_RspId,
  output logic                BRC_o_RspResult,
  output logic                BRC_o_RspErr,
  input  logic                BRC_i_RspReady
);
  import brc_pkg::*;

  brc_state_e r_state, w_state_nxt;

  logic [1:0]        w_grant;
  logic [1:0]        w_ready;
  logic              w_accept;
  logic              w_win_id;
  logic [MODE_W-1:0] w_win_mode;
  logic              w_mode_bad;
  logic              r_cmp_id;
  logic              r_cmp_err;

  brc_starve_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .i_clk   (BRC_i_Clk),
    .i_rst   (BRC_i_Reset),
    .i_idle  (r_state == ST_IDLE),
    .i_valid (BRC_i_ReqValid),
    .o_grant (w_grant)
  );

  // Ready only offered in IDLE, and never while reset is held
  assign w_ready        = (r_state == ST_IDLE && !BRC_i_Reset) ? w_grant : 2'b00;
  assign w_accept       = |w_ready;
  assign BRC_o_ReqReady = w_ready;
  assign w_win_id       = w_grant[REQ_ID_TRAP];
  assign w_win_mode     = w_win_id ? BRC_i_ReqMode[2*MODE_W-1:MODE_W]
                                   : BRC_i_ReqMode[MODE_W-1:0];

`ifdef BRC_MODE_CHECK_EN
  assign w_mode_bad = (32'(w_win_mode) > MODE_MAX);
`else
  assign w_mode_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge BRC_i_Clk or posedge BRC_i_Reset) begin
    if (BRC_i_Reset) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next state: accept -> one eval cycle -> hold response until taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)       w_state_nxt = ST_EVAL;
      ST_EVAL:                     w_state_nxt = ST_RESP;
      ST_RESP: if (BRC_i_RspReady) w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  // Comparator operand registers, loaded only on accept
  always_ff @(posedge BRC_i_Clk or posedge BRC_i_Reset) begin
    if (BRC_i_Reset) begin
      BRC_o_CmpRs   <= '0;
      BRC_o_CmpRt   <= '0;
      BRC_o_CmpMode <= '0;
      r_cmp_id      <= 1'b0;
      r_cmp_err     <= 1'b0;
    end else if (w_accept) begin
      BRC_o_CmpRs   <= w_win_id ? BRC_i_ReqRs[2*DW-1:DW] : BRC_i_ReqRs[DW-1:0];
      BRC_o_CmpRt   <= w_win_id ? BRC_i_ReqRt[2*DW-1:DW] : BRC_i_ReqRt[DW-1:0];
      BRC_o_CmpMode <= w_mode_bad ? '0 : w_win_mode;
      r_cmp_id      <= w_win_id;
      r_cmp_err     <= w_mode_bad;
    end
  end

  // Response registers: capture in EVAL, hold through RESP until taken
  always_ff @(posedge BRC_i_Clk or posedge BRC_i_Reset) begin
    if (BRC_i_Reset) begin
      BRC_o_RspValid  <= 1'b0;
      BRC_o_RspId     <= 1'b0;
      BRC_o_RspResult <= 1'b0;
      BRC_o_RspErr    <= 1'b0;
    end else if (r_state == ST_EVAL) begin
      BRC_o_RspValid  <= 1'b1;
      BRC_o_RspId     <= r_cmp_id;
      BRC_o_RspResult <= r_cmp_err ? 1'b0 : BRC_i_CmpResult;
      BRC_o_RspErr    <= r_cmp_err;
    end else if (r_state == ST_RESP && BRC_i_RspReady) begin
      BRC_o_RspValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a behavioural comparator.
module tb_branch_resolve_ctrl;
  localparam int DW = 32;
  localparam int MW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      valid = 2'b00;
  logic [2*DW-1:0] rs = '0;
  logic [2*DW-1:0] rt = '0;
  logic [2*MW-1:0] mode = '0;
  logic [1:0]      req_ready;
  logic [DW-1:0]   cmp_rs, cmp_rt;
  logic [MW-1:0]   cmp_mode;
  logic            cmp_result;
  logic            rsp_valid, rsp_id, rsp_result, rsp_err;
  logic            rsp_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.DW(DW), .MODE_W(MW), .STARVE_LIM(3)) dut (
    .BRC_i_Clk       (clk),
    .BRC_i_Reset     (rst),
    .BRC_i_ReqValid  (valid),
    .BRC_i_ReqRs     (rs),
    .BRC_i_ReqRt     (rt),
    .BRC_i_ReqMode   (mode),
    .BRC_o_ReqReady  (req_ready),
    .BRC_o_CmpRs     (cmp_rs),
    .BRC_o_CmpRt     (cmp_rt),
    .BRC_o_CmpMode   (cmp_mode),
    .BRC_i_CmpResult (cmp_result),
    .BRC_o_RspValid  (rsp_valid),
    .BRC_o_RspId     (rsp_id),
    .BRC_o_RspResult (rsp_result),
    .BRC_o_RspErr    (rsp_err),
    .BRC_i_RspReady  (rsp_ready)
  );

  // Comparator: 0 eq, 1 ne, 2 lt, 3 ge, 4 ltu, 5 geu, others always true
  always_comb begin
    case (cmp_mode)
      4'd0:    cmp_result = (cmp_rs == cmp_rt);
      4'd1:    cmp_result = (cmp_rs != cmp_rt);
      4'd2:    cmp_result = ($signed(cmp_rs) <  $signed(cmp_rt));
      4'd3:    cmp_result = ($signed(cmp_rs) >= $signed(cmp_rt));
      4'd4:    cmp_result = (cmp_rs <  cmp_rt);
      4'd5:    cmp_result = (cmp_rs >= cmp_rt);
      default: cmp_result = 1'b1;
    endcase
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 2'b00; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    valid = 2'b00; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rspvalid got=%b exp=0", rsp_valid); end
    total++; if ({cmp_rs, cmp_rt, cmp_mode} !== '0) begin bad++; $display("FAIL reset_cmp got=%h/%h/%h exp=0", cmp_rs, cmp_rt, cmp_mode); end
    total++; if ({rsp_id, rsp_result, rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%b exp=000", {rsp_id, rsp_result, rsp_err}); end
    @(negedge clk);
    total++; if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_held got=%b/%b exp=00/0", req_ready, rsp_valid); end
    rst = 1'b0; valid = 2'b00;
  endtask

  task automatic test_single();
    do_reset();
    valid = 2'b01; rs[DW-1:0] = 32'd10; rt[DW-1:0] = 32'd10; mode[MW-1:0] = 4'd0; rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    valid = 2'b00;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL single_ready_drop got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    total++; if (cmp_rs !== 32'd10 || cmp_mode !== 4'd0) begin bad++; $display("FAIL single_cmp got=%h/%h exp=a/0", cmp_rs, cmp_mode); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== 4'b1010) begin bad++; $display("FAIL single_rsp got=%b exp=1010", {rsp_valid, rsp_id, rsp_result, rsp_err}); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_taken got=%b exp=0", rsp_valid); end
    drain();
  endtask

  task automatic test_starve();
    logic [7:0] seq;
    logic [7:0] exp_seq;
    int n;
    exp_seq = 8'b1000_1000;  // bit i = requester granted on accept i
    seq = '0; n = 0;
    do_reset();
    rsp_ready = 1'b1; valid = 2'b11;
    rs = {32'd3, 32'd1}; rt = {32'd3, 32'd2}; mode = '0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        total++; if (req_ready !== 2'b01 && req_ready !== 2'b10) begin bad++; $display("FAIL starve_onehot got=%b", req_ready); end
        seq[n] = req_ready[1];
        n++;
      end
      @(negedge clk);
    end
    total++; if (n !== 8) begin bad++; $display("FAIL starve_timeout got=%0d exp=8 accepts", n); end
    total++; if (seq !== exp_seq) begin bad++; $display("FAIL starve_seq got=%b exp=%b (bit0 first)", seq, exp_seq); end
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0; valid = 2'b01;
    rs = {32'd5, 32'd7}; rt = {32'd5, 32'd9}; mode = {4'd0, 4'd2};
    @(negedge clk);
    valid = 2'b11; rs[DW-1:0] = 32'd11;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result} !== 3'b101) begin bad++; $display("FAIL bp_rsp got=%b exp=101", {rsp_valid, rsp_id, rsp_result}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== 4'b1010 || req_ready !== 2'b00 || cmp_rs !== 32'd7) begin
        bad++; $display("FAIL bp_hold%0d got=%b ready=%b cmprs=%0d exp=1010/00/7", i, {rsp_valid, rsp_id, rsp_result, rsp_err}, req_ready, cmp_rs);
      end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL bp_take_ready got=%b exp=00", req_ready); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin bad++; $display("FAIL bp_after got=%b/%b exp=0/01", rsp_valid, req_ready); end
    @(negedge clk);
    total++; if (cmp_rs !== 32'd11) begin bad++; $display("FAIL bp_next_accept got=%0d exp=11", cmp_rs); end
    drain();
  endtask

  task automatic test_reset_eval();
    do_reset();
    rsp_ready = 1'b1; valid = 2'b01;
    rs[DW-1:0] = 32'hFFFF_FF47; rt[DW-1:0] = 32'd32; mode[MW-1:0] = 4'd2;
    @(negedge clk);
    valid = 2'b00;
    total++; if (cmp_rs !== 32'hFFFF_FF47) begin bad++; $display("FAIL rste_cmp got=%h exp=ffffff47", cmp_rs); end
    rst = 1'b1;
    #1;
    total++; if ({cmp_rs, cmp_rt, cmp_mode} !== '0 || {rsp_valid, rsp_id, rsp_result, rsp_err} !== 4'b0 || req_ready !== 2'b00) begin
      bad++; $display("FAIL rste_clear got=%h/%h/%h rsp=%b ready=%b exp=0", cmp_rs, cmp_rt, cmp_mode, {rsp_valid, rsp_id, rsp_result, rsp_err}, req_ready);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rste_norsp1 got=%b exp=0", rsp_valid); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rste_norsp2 got=%b exp=0", rsp_valid); end
    valid = 2'b10; rs[2*DW-1:DW] = 32'd5; rt[2*DW-1:DW] = 32'd3; mode[2*MW-1:MW] = 4'd3;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rste_ready got=%b exp=10", req_ready); end
    @(negedge clk);
    valid = 2'b00;
    @(negedge clk);
    total++; if ({rsp_valid, rsp_id, rsp_result, rsp_err} !== 4'b1110) begin bad++; $display("FAIL rste_after got=%b exp=1110", {rsp_valid, rsp_id, rsp_result, rsp_err}); end
    drain();
  endtask

  task automatic test_mode7();
    logic [MW-1:0] exp_mode;
    logic [1:0]    exp_res_err;
`ifdef BRC_MODE_CHECK_EN
    exp_mode = 4'd0; exp_res_err = 2'b01;
`else
    exp_mode = 4'd7; exp_res_err = 2'b10;
`endif
    do_reset();
    rsp_ready = 1'b1; valid = 2'b01;
    rs[DW-1:0] = 32'd4; rt[DW-1:0] = 32'd4; mode[MW-1:0] = 4'd7;
    @(negedge clk);
    valid = 2'b00;
    total++; if (cmp_mode !== exp_mode) begin bad++; $display("FAIL mode7_cmpmode got=%0d exp=%0d", cmp_mode, exp_mode); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || {rsp_result, rsp_err} !== exp_res_err) begin
      bad++; $display("FAIL mode7_rsp got=v%b r%b e%b exp=v1 r%b e%b", rsp_valid, rsp_result, rsp_err, exp_res_err[1], exp_res_err[0]);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_starve();
    test_backpressure();
    test_reset_eval();
    test_mode7();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter DW, 32, operand width.
REQ-002 Parameter MODE_W, 4, comparator mode width.
REQ-003 Parameter STARVE_LIM, 3, consecutive lost arbitration cycles after which requester 1 wins.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-005 BRC_i_Clk  in  1  clock, rising edge.
REQ-006 BRC_i_Reset  in  1  asynchronous active-high reset.
REQ-007 BRC_i_ReqValid  in  2  bit n = requester n has a compare pending; requester 0 is the ID branch, requester 1 is the EX conditional trap.
REQ-008 BRC_i_ReqRs  in  2*DW  packed {req1,req0} Rs operands.
REQ-009 BRC_i_ReqRt  in  2*DW  packed {req1,req0} Rt operands.
REQ-010 BRC_i_ReqMode  in  2*MODE_W  packed {req1,req0} compare modes.
REQ-011 BRC_o_ReqReady  out  2  bit n = request n accepted this cycle; one-hot or zero.
REQ-012 BRC_o_CmpRs / BRC_o_CmpRt  out  DW each  registered operands to the shared CMP.
REQ-013 BRC_o_CmpMode  out  MODE_W  registered mode to the shared CMP.
REQ-014 BRC_i_CmpResult  in  1  combinational CMP result.
REQ-015 BRC_o_RspValid  out  1  response available.
REQ-016 BRC_o_RspId  out  1  requester owning the response.
REQ-017 BRC_o_RspResult  out  1  captured compare result.
REQ-018 BRC_o_RspErr  out  1  illegal mode flag.
REQ-019 BRC_i_RspReady  in  1  consumer takes response.

Function
REQ-020 The FSM SHALL have states IDLE, EVAL and RESP, with one transaction outstanding at most.
REQ-021 ReqReady SHALL be non-zero only in IDLE; the request is accepted on the edge where its Valid and Ready are both 1, and the FSM then moves IDLE->EVAL.
REQ-022 Grant in IDLE SHALL be: req0 if valid, unless the starvation counter equals STARVE_LIM and req1 is valid, in which case req1 wins.
REQ-023 The starvation counter SHALL increment (saturating at STARVE_LIM) on each IDLE cycle where req1 is valid but not granted, and SHALL clear on a req1 grant.
REQ-024 On accept, the Rs, Rt, Mode and id of the winner SHALL be latched into Cmp* registers; Cmp* outputs SHALL hold until the next accept.
REQ-025 In EVAL, CmpResult SHALL be captured into RspResult on the next edge, with EVAL->RESP; RspValid SHALL be 1 throughout RESP.
REQ-026 Latency SHALL be: RspValid high exactly 2 edges after the accept edge.
REQ-027 In RESP, if RspReady=1 then RESP->IDLE on that edge; otherwise Rsp* outputs SHALL hold stable.
REQ-028 A new request SHALL NOT be accepted in the same cycle a response is taken; the minimum period is 3 cycles per compare.
REQ-029 Valid deasserting before accept SHALL leave no state change except the starvation counter rule.

Reset
REQ-030 Reset SHALL force IDLE, starvation counter 0, ReqReady 0 while asserted, Cmp* 0, and RspValid/RspId/RspResult/RspErr 0.
REQ-031 Reset asserted in EVAL or RESP SHALL discard the in-flight transaction with no response emitted.

Configuration
REQ-032 With BRC_MODE_CHECK_EN defined, an accepted mode greater than 6 SHALL produce RspErr=1 and RspResult=0 with normal latency, and BRC_o_CmpMode SHALL be driven to 0.
REQ-033 Without BRC_MODE_CHECK_EN, the mode SHALL pass through unchecked and RspErr SHALL be tied to 0.

Structure
REQ-034 Package brc_pkg SHALL hold the state encoding, MODE_MAX=6 and the requester id constants.
REQ-035 Sub-module brc_starve_arb SHALL contain the grant logic and the starvation counter; CMP SHALL remain external.

Verification
REQ-036 req0 only, Rs=10, Rt=10, mode 0, CMP model returns 1 -> Ready[0] for 1 cycle, RspValid 2 edges later with Id=0, Result=1.
REQ-037 Both requesters valid continuously, RspReady=1 -> grant sequence 0,0,0,1,0,0,0,1 with STARVE_LIM=3.
REQ-038 RspReady held 0 for 5 cycles -> Rsp* stable, ReqReady=00, no new accept; the accept occurs 1 cycle after RspReady=1.
REQ-039 Reset pulsed in EVAL with Rs=-185, Rt=32 -> no RspValid, all outputs 0, and the next request completes normally.
REQ-040 Mode 7 with BRC_MODE_CHECK_EN -> RspErr=1, Result=0, CmpMode=0; without the macro -> CmpMode=7, RspErr=0.
